// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: default widths, op codes, FSM states.
// Build option: define SHIFT_CARRY_EN to add the out_carry port on iterative_shift_unit.
package shift_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_AMT_W = 3;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SLA = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Single 1-bit shift stage; carry is the bit that falls off the word.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] q,
  output logic             carry
);

  // One shift position; SLL and SLA behave identically
  always_comb begin
    q     = d;
    carry = 1'b0;
    case (op)
      OP_SLL, OP_SLA: begin
        q     = {d[WIDTH-2:0], 1'b0};
        carry = d[WIDTH-1];
      end
      OP_SRL: begin
        q     = {1'b0, d[WIDTH-1:1]};
        carry = d[0];
      end
      OP_SRA: begin
        q     = {d[WIDTH-1], d[WIDTH-1:1]};
        carry = d[0];
      end
      default: begin
        q     = d;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shifter: accepts one command, applies one bit of shift per clock,
// then holds the result until the consumer takes it.
// Build option: SHIFT_CARRY_EN adds out_carry (last bit shifted out, 0 for amt=0).
module iterative_shift_unit
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SHIFT_CARRY_EN
  output logic             out_carry,
`endif
  output logic [WIDTH-1:0] out_data
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [AMT_W-1:0]   count_q, count_d;
  logic [1:0]         op_q, op_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   step_data;
  logic               step_carry;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .d     (data_q),
    .op    (op_q),
    .q     (step_data),
    .carry (step_carry)
  );

  // Next-state, datapath update and registered handshake outputs
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    op_d    = op_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          data_d  = in_data;
          op_d    = in_op;
          count_d = in_amt;
          carry_d = 1'b0;
          state_d = (in_amt != AMT_W'(0)) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        data_d  = step_data;
        carry_d = step_carry;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      count_q     <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      count_q     <= count_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;

`ifdef SHIFT_CARRY_EN
  assign out_carry = carry_q;
`else
  logic unused_carry;
  assign unused_carry = carry_q;
`endif

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench for iterative_shift_unit (4-bit data, 3-bit amount).
module tb_iterative_shift_unit;
  import shift_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_op;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
`ifdef SHIFT_CARRY_EN
  logic       out_carry;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_hs  = 0;
  int n_cmd = 0;

  iterative_shift_unit #(.WIDTH(4), .AMT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SHIFT_CARRY_EN
    .out_carry (out_carry),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every output handshake to detect dropped or duplicated results
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) n_hs <= n_hs + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: iterate single-bit shifts; returns {carry, data}
  function automatic logic [4:0] ref_shift(input logic [3:0] d, input logic [1:0] op,
                                           input logic [2:0] amt);
    logic [3:0] v;
    logic       c;
    v = d;
    c = 1'b0;
    for (int k = 0; k < int'(amt); k++) begin
      if (op == OP_SRL || op == OP_SRA) begin
        c = v[0];
        v = {(op == OP_SRA) ? v[3] : 1'b0, v[3:1]};
      end else begin
        c = v[3];
        v = {v[2:0], 1'b0};
      end
    end
    return {c, v};
  endfunction

  task automatic check_carry(input string tag, input logic exp_c);
`ifdef SHIFT_CARRY_EN
    check({tag, "_carry"}, 8'(out_carry), 8'(exp_c));
`else
    if (exp_c === 1'bx) $display("unreachable");
`endif
  endtask

  // Apply one command with out_ready high; check latency, result and return to idle
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] d,
                         input logic [2:0] amt, input logic [3:0] exp_d, input logic exp_c);
    int cyc;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = amt; out_ready = 1'b1;
    check({tag, "_in_ready"}, 8'(in_ready), 8'd1);
    @(posedge clk); #1;
    n_cmd++;
    in_valid = 1'b0; in_data = ~d; in_op = ~op; in_amt = ~amt;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 8'(cyc), 8'(int'(amt) + 1));
    check({tag, "_data"}, 8'(out_data), 8'(exp_d));
    check_carry(tag, exp_c);
    @(posedge clk); #1;
    check({tag, "_ready_after"}, 8'(in_ready), 8'd1);
    check({tag, "_valid_after"}, 8'(out_valid), 8'd0);
  endtask

  initial begin
    logic [4:0] exp;
    logic [3:0] rd;
    logic [1:0] rop;
    logic [2:0] ramt;
    int         cyc;
    int         gap;

    rst_n = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 8'(in_ready), 8'd1);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_data", 8'(out_data), 8'd0);
    #10 rst_n = 1'b1;

    run_cmd("sra_1010_a2", OP_SRA, 4'b1010, 3'd2, 4'b1110, 1'b1);
    run_cmd("srl_1000_a3", OP_SRL, 4'b1000, 3'd3, 4'b0001, 1'b0);
    run_cmd("sra_1000_a3", OP_SRA, 4'b1000, 3'd3, 4'b1111, 1'b0);
    run_cmd("srl_1001_a0", OP_SRL, 4'b1001, 3'd0, 4'b1001, 1'b0);
    run_cmd("sll_1011_a7", OP_SLL, 4'b1011, 3'd7, 4'b0000, 1'b0);
    run_cmd("sla_0011_a2", OP_SLA, 4'b0011, 3'd2, 4'b1100, 1'b0);
    run_cmd("sra_0110_a7", OP_SRA, 4'b0110, 3'd7, 4'b0000, 1'b0);

    // Backpressure: second command presented while the first result is held
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = OP_SLL; in_data = 4'b0111; in_amt = 3'd1; out_ready = 1'b0;
    @(posedge clk); #1;
    n_cmd++;
    in_op = OP_SRL; in_data = 4'b1010; in_amt = 3'd2;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_latency", 8'(cyc), 8'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_data", 8'(out_data), 8'b1110);
      check("bp_hold_valid", 8'(out_valid), 8'd1);
      check("bp_hold_ready", 8'(in_ready), 8'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 8'(in_ready), 8'd1);
    check("bp_release_valid", 8'(out_valid), 8'd0);
    @(posedge clk); #1;
    n_cmd++;
    in_valid = 1'b0;
    check("bp_second_accepted", 8'(in_ready), 8'd0);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_second_latency", 8'(cyc), 8'd3);
    check("bp_second_data", 8'(out_data), 8'b0010);
    check_carry("bp_second", 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a long shift
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = OP_SLL; in_data = 4'b0001; in_amt = 3'd6; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 8'(out_valid), 8'd0);
    check("mid_rst_data", 8'(out_data), 8'd0);
    check("mid_rst_ready", 8'(in_ready), 8'd1);
    #10 rst_n = 1'b1;
    run_cmd("post_rst_srl", OP_SRL, 4'b1100, 3'd1, 4'b0110, 1'b0);

    // Random commands with random consumer stalls
    for (int i = 0; i < 10; i++) begin
      rd = 4'($urandom); rop = 2'($urandom); ramt = 3'($urandom);
      exp = ref_shift(rd, rop, ramt);
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = rop; in_data = rd; in_amt = ramt; out_ready = 1'b0;
      @(posedge clk); #1;
      n_cmd++;
      in_valid = 1'b0; in_data = 4'($urandom);
      cyc = 1;
      while (!out_valid && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("rnd_latency", 8'(cyc), 8'(int'(ramt) + 1));
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk); #1;
        check("rnd_stall_valid", 8'(out_valid), 8'd1);
      end
      check("rnd_data", 8'(out_data), 8'(exp[3:0]));
      check_carry("rnd", exp[4]);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("rnd_valid_after", 8'(out_valid), 8'd0);
      check("rnd_ready_after", 8'(in_ready), 8'd1);
    end

    repeat (2) @(posedge clk);
    #1;
    check("handshake_count", 8'(n_hs), 8'(n_cmd));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
